sum_engine: RTL and testbench

//  Compute-side user core between the control-thread command channel and the 1-port data memory.
//  - Dequeues a 2-word command {base, size} from the channel.
//  - Streams `size` words from memory starting at `base` and sums them.
//  - Writes the sum back to memory at base+size, then enqueues the sum to the control thread.

---
 rtl/sum_engine_pkg.sv | 15 +
 rtl/sum_engine_if.sv | 28 ++
 rtl/sum_engine_accum.sv | 32 +++
 rtl/sum_engine.sv | 115 +++++++++++
 tb/tb_sum_engine.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sum_engine_pkg.sv
// sum_engine_pkg: shared widths and FSM state encoding for the sum engine.
package sum_engine_pkg;
  localparam int W_A_DEF = 13;
  localparam int W_D_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    CMD_BASE,
    CMD_SIZE,
    READ,
    DRAIN,
    WRITE,
    SEND
  } state_t;
endpackage

// File: rtl/sum_engine_if.sv
// sum_engine_if: memory port and control-thread channel seen by the sum engine.
interface sum_engine_if import sum_engine_pkg::*; #(
  parameter int W_A = W_A_DEF,
  parameter int W_D = W_D_DEF
) ();
  logic [W_A-1:0] mem_addr;
  logic [W_D-1:0] mem_d;
  logic           mem_we;
  logic [W_D-1:0] mem_q;
  logic [W_D-1:0] comm_d;
  logic           comm_enq;
  logic           comm_full;
  logic [W_D-1:0] comm_q;
  logic           comm_deq;
  logic           comm_empty;

  // Engine side.
  modport master (
    output mem_addr, mem_d, mem_we, comm_d, comm_enq, comm_deq,
    input  mem_q, comm_full, comm_q, comm_empty
  );

  // Memory / channel side.
  modport slave (
    input  mem_addr, mem_d, mem_we, comm_d, comm_enq, comm_deq,
    output mem_q, comm_full, comm_q, comm_empty
  );
endinterface

// File: rtl/sum_engine_accum.sv
// sum_accum: adds memory read data one cycle after the read was issued.
// i_rd_valid marks the issue cycle; it is delayed here to line up with mem_q.
module sum_accum import sum_engine_pkg::*; #(
  parameter int W_D = W_D_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clr,
  input  logic           i_rd_valid,
  input  logic [W_D-1:0] i_data,
  output logic [W_D-1:0] o_sum
);
  logic           r_vld;
  logic [W_D-1:0] r_sum;

  // Valid pipeline plus wrapping accumulator; clear wins over add.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= 1'b0;
      r_sum <= '0;
    end else begin
      r_vld <= i_rd_valid;
      if (i_clr) begin
        r_sum <= '0;
      end else if (r_vld) begin
        r_sum <= r_sum + i_data;
      end
    end
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/sum_engine.sv
// sum_engine: dequeues {base, size}, sums size words from base, writes the sum
// to base+size and enqueues it back to the control thread.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for a command; dequeues the base word
//   CMD_BASE | latches base; dequeues the size word when available
//   CMD_SIZE | latches size, clears the sum, picks READ or WRITE
//   READ     | issues one read address per cycle, size issues total
//   DRAIN    | lets the last read data reach the accumulator
//   WRITE    | writes the sum to base+size (one cycle)
//   SEND     | enqueues the sum; stalls while the channel is full
module sum_engine import sum_engine_pkg::*; #(
  parameter int W_A = W_A_DEF,
  parameter int W_D = W_D_DEF
) (
  input logic           CLK,
  input logic           RST,
  sum_engine_if.master  io_bus
);
  localparam logic [W_A-1:0] ONE_A = W_A'(1);
  localparam logic [W_D-1:0] ONE_D = W_D'(1);

  state_t         r_state;
  logic           r_base_ld;
  logic [W_A-1:0] r_base;
  logic [W_A-1:0] r_wr_addr;
  logic [W_A-1:0] r_addr;
  logic [W_D-1:0] r_cnt;
  logic [W_D-1:0] w_sum;
  logic           w_rd_valid;
  logic           w_clr;

  assign w_rd_valid = (r_state == READ);
  assign w_clr      = (r_state == CMD_SIZE);

  sum_accum #(.W_D(W_D)) u_accum (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clr      (w_clr),
    .i_rd_valid (w_rd_valid),
    .i_data     (io_bus.mem_q),
    .o_sum      (w_sum)
  );

  // Command sequencing; r_cnt is a down-counter of remaining read issues.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_base_ld <= 1'b0;
      r_base    <= '0;
      r_wr_addr <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!io_bus.comm_empty) begin
            r_state   <= CMD_BASE;
            r_base_ld <= 1'b1;
          end
        end
        CMD_BASE: begin
          // comm_q carries the base only in the first cycle after its dequeue.
          if (r_base_ld) begin
            r_base    <= io_bus.comm_q[W_A-1:0];
            r_base_ld <= 1'b0;
          end
          if (!io_bus.comm_empty) begin
            r_state <= CMD_SIZE;
          end
        end
        CMD_SIZE: begin
          r_cnt     <= io_bus.comm_q;
          r_wr_addr <= r_base + io_bus.comm_q[W_A-1:0];
          // For size 0 base is also the write-back address.
          r_addr    <= r_base;
          r_state   <= (io_bus.comm_q == '0) ? WRITE : READ;
        end
        READ: begin
          if (r_cnt == ONE_D) begin
            r_state <= DRAIN;
          end else begin
            r_cnt  <= r_cnt - ONE_D;
            r_addr <= r_addr + ONE_A;
          end
        end
        DRAIN: begin
          r_addr  <= r_wr_addr;
          r_state <= WRITE;
        end
        WRITE: begin
          r_state <= SEND;
        end
        SEND: begin
          if (!io_bus.comm_full) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, apart from the channel status gates.
  assign io_bus.mem_addr = RST ? '0 : r_addr;
  assign io_bus.mem_we   = !RST && (r_state == WRITE);
  assign io_bus.mem_d    = io_bus.mem_we ? w_sum : '0;
  assign io_bus.comm_deq = !RST && !io_bus.comm_empty &&
                           ((r_state == IDLE) || (r_state == CMD_BASE));
  assign io_bus.comm_enq = !RST && (r_state == SEND) && !io_bus.comm_full;
  assign io_bus.comm_d   = (!RST && (r_state == SEND)) ? w_sum : '0;
endmodule

// File: tb/tb_sum_engine.sv
// tb_sum_engine: directed commands against a 1-cycle memory and a 16-deep
// command channel; a negedge monitor checks writes and results from queues.
module tb_sum_engine;
  localparam int W_A = 13;
  localparam int W_D = 32;

  typedef struct { logic [31:0] d; int lat; } exp_res_t;
  typedef struct { logic [12:0] a; logic [31:0] d; } exp_wr_t;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   deq_cnt = 0;
  int   n_cmds = 0;
  int   sz_cyc = 0;

  exp_res_t exp_res[$];
  exp_wr_t  exp_wr[$];

  logic [31:0] mem [8192];
  logic [31:0] fifo [16];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  sum_engine_if #(.W_A(W_A), .W_D(W_D)) bus ();

  sum_engine #(.W_A(W_A), .W_D(W_D)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .io_bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // 1-cycle latency memory: read data registered, write on the same edge.
  always @(posedge CLK) begin
    bus.mem_q <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_d;
  end

  // Command channel with registered output.
  assign bus.comm_empty = (wr_ptr == rd_ptr);
  always @(posedge CLK) begin
    if (bus.comm_deq) begin
      bus.comm_q <= fifo[rd_ptr % 16];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every write and every enqueue against the scoreboard.
  always @(negedge CLK) begin : mon
    exp_res_t er;
    exp_wr_t  ew;
    if (RST) begin
      chk("rst_outputs",
          {bus.mem_we, bus.comm_enq, bus.comm_deq, (bus.mem_addr != '0),
           (bus.mem_d != '0), (bus.comm_d != '0)}, 32'd0);
    end else begin
      if (!bus.mem_we && bus.mem_d != '0) begin
        errors++;
        $display("FAIL mem_d_idle got %0h want 0", bus.mem_d);
      end
      if (bus.comm_deq) begin
        chk("deq_when_empty", 32'(bus.comm_empty), 32'd0);
        deq_cnt++;
        if (deq_cnt % 2 == 0) begin
          sz_cyc = cyc;
          n_cmds++;
        end
      end
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_addr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        end else begin
          ew = exp_wr.pop_front();
          chk("write_addr", 32'(bus.mem_addr), 32'(ew.a));
          chk("write_data", bus.mem_d, ew.d);
        end
      end
      if (bus.comm_enq) begin
        chk("enq_when_full", 32'(bus.comm_full), 32'd0);
        if (exp_res.size() == 0) begin
          errors++;
          $display("FAIL unexpected_enq got %0h want none", bus.comm_d);
        end else begin
          er = exp_res.pop_front();
          chk("result_data", bus.comm_d, er.d);
          if (er.lat >= 0) chk("result_latency", 32'(cyc - sz_cyc), 32'(er.lat));
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    fifo[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  task automatic expect_cmd(input logic [31:0] d, input int lat, input logic [12:0] wa);
    exp_res_t er;
    exp_wr_t  ew;
    er.d = d; er.lat = lat;
    ew.a = wa; ew.d = d;
    exp_res.push_back(er);
    exp_wr.push_back(ew);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while ((exp_res.size() != 0 || exp_wr.size() != 0) && k < 400) begin
      @(posedge CLK);
      k++;
    end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (exp_res.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending %0d results %0d writes want 0",
               nm, exp_res.size(), exp_wr.size());
      exp_res.delete();
      exp_wr.delete();
    end
  endtask

  task automatic wait_cmd(input int n, input string nm);
    int k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (n_cmds == n && k < 50);
    checks++;
    if (n_cmds == n) begin
      errors++;
      $display("FAIL %s size dequeue not seen after %0d cycles", nm, k);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1;
    bus.comm_full = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_strobes", {bus.mem_we, bus.comm_enq, bus.comm_deq}, 32'd0);
    @(posedge CLK);
    #1;

    // 1: sum of four words, latency size+4.
    for (int i = 0; i < 4; i++) mem[i] = i + 1;
    expect_cmd(32'd10, 8, 13'd4);
    push_word(32'd0); push_word(32'd4);
    wait_done("t1");
    chk("t1_mem4", mem[4], 32'd10);

    // 2: size 0 writes 0 at base.
    mem[100] = 32'h55;
    expect_cmd(32'd0, 3, 13'd100);
    push_word(32'd100); push_word(32'd0);
    wait_done("t2");
    chk("t2_mem100", mem[100], 32'd0);

    // 4: channel full for 20 cycles in SEND.
    bus.comm_full = 1'b1;
    n = n_cmds;
    expect_cmd(32'd10, 28, 13'd4);
    push_word(32'd0); push_word(32'd4);
    wait_cmd(n, "t4");
    repeat (27) @(posedge CLK);
    #1 bus.comm_full = 1'b0;
    wait_done("t4");

    // 3: address wrap and modulo sum.
    mem[8190] = 32'hFFFF_FFFF; mem[8191] = 32'd2; mem[0] = 32'd5;
    expect_cmd(32'd6, 7, 13'd1);
    push_word(32'd8190); push_word(32'd3);
    wait_done("t3");
    chk("t3_mem1", mem[1], 32'd6);

    // 5: reset mid-READ discards the command.
    for (int i = 0; i < 100; i++) mem[i] = i + 1;
    mem[100] = 32'hDEAD;
    n = n_cmds;
    push_word(32'd0); push_word(32'd100);
    wait_cmd(n, "t5");
    repeat (20) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    mem[0] = 32'd7; mem[1] = 32'd9;
    expect_cmd(32'd16, 6, 13'd2);
    push_word(32'd0); push_word(32'd2);
    wait_done("t5");
    chk("t5_mem100_untouched", mem[100], 32'hDEAD);

    // 6: size word arrives 5 cycles after the base word.
    mem[10] = 32'd100; mem[11] = 32'd200; mem[12] = 32'd300;
    n = n_cmds;
    push_word(32'd10);
    @(posedge CLK);
    repeat (5) begin
      @(negedge CLK);
      chk("t6_deq_stall", 32'(bus.comm_deq), 32'd0);
    end
    chk("t6_no_size_deq", 32'(n_cmds), 32'(n));
    @(posedge CLK);
    #1;
    expect_cmd(32'd600, 7, 13'd13);
    push_word(32'd3);
    wait_done("t6");
    chk("t6_mem13", mem[13], 32'd600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
